// File: rtl/hazard_pkg.sv
// Purpose : shared types and the RAW-match helper for the pipeline hazard controller.
// Latency : n/a (types and a pure combinational function only).
// Backpr. : n/a.
//
// Register indices are carried through raw_match() at RIDX_W bits; callers
// zero-extend their RW-bit indices, so REG_COUNT up to 256 is supported.
package hazard_pkg;

    localparam int RIDX_W = 8;

    // EX operand mux select: regfile, MEM/WB result, EX/MEM result.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_RAW  = 2'b01,
        CAUSE_MDU  = 2'b10,
        CAUSE_MEM  = 2'b11
    } stall_cause_e;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } hz_state_e;

    // A producer satisfies a consumer's source only if it really writes a
    // non-x0 register and the consumer really reads that source.
    function automatic logic raw_match(
        input logic [RIDX_W-1:0] rd,
        input logic              reg_write,
        input logic [RIDX_W-1:0] rs,
        input logic              use_rs
    );
        return reg_write && (rd != '0) && (rd == rs) && use_rs;
    endfunction

endpackage

// File: rtl/hazard_mdu_timer.sv
// Purpose : down-counter tracking how long a multi-cycle MDU op still occupies EX.
// Latency : load/decrement take effect on the next clk edge; done is combinational from the count.
// Backpr. : dec low holds the count (used to freeze it during a data-memory wait).
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset (count -> 0)
//   load        load LOAD_VAL (has priority over dec)
//   dec         decrement by one, saturating at zero
//   done        count is zero: the op is on its final EX cycle
module hazard_mdu_timer #(
    parameter int CNT_W    = 4,
    parameter int LOAD_VAL = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic done
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(LOAD_VAL);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Purpose : five-stage pipeline hazard control: stalls, bubbles, flushes and EX forwarding selects.
// Latency : all controls are combinational from the current stage info; FSM, MDU count and perf counter are registered.
// Backpr. : a data-memory wait freezes PC..EX/MEM and bubbles MEM/WB; MDU and RAW hazards stall the front end.
//
// Build option: HAZARD_FORWARDING_EN enables the EX forward muxes and limits RAW stalls to load-use;
// without it the selects are tied to regfile and any in-flight producer of an ID source stalls ID.
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   if_id_rs1/rs2, if_id_use_rs1/rs2   ID-stage sources and whether they are read
//   id_ex_rs1/rs2/rd, id_ex_reg_write, id_ex_mem_read, id_ex_is_mdu   EX-stage info
//   ex_mem_rd/reg_write, mem_wb_rd/reg_write                          later-stage producers
//   ex_redirect                        taken branch/jump resolved in EX
//   dmem_req, dmem_ready               MEM-stage access handshake
//   *_write_en, if_id_flush, *_bubble  pipeline register controls
//   fwd_a_sel, fwd_b_sel               EX operand muxes (00 RF, 01 MEM/WB, 10 EX/MEM)
//   stall_cause                        00 none, 01 RAW, 10 MDU, 11 mem wait
//   perf_stall_cnt                     saturating count of stalled cycles
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int  REG_COUNT   = 32,
    parameter int  MDU_LATENCY = 8,
    parameter int  PERF_W      = 32,
    localparam int RW          = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RW-1:0]     if_id_rs1,
    input  logic [RW-1:0]     if_id_rs2,
    input  logic              if_id_use_rs1,
    input  logic              if_id_use_rs2,
    input  logic [RW-1:0]     id_ex_rs1,
    input  logic [RW-1:0]     id_ex_rs2,
    input  logic [RW-1:0]     id_ex_rd,
    input  logic              id_ex_reg_write,
    input  logic              id_ex_mem_read,
    input  logic              id_ex_is_mdu,
    input  logic [RW-1:0]     ex_mem_rd,
    input  logic [RW-1:0]     mem_wb_rd,
    input  logic              ex_mem_reg_write,
    input  logic              mem_wb_reg_write,
    input  logic              ex_redirect,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_write_en,
    output logic              if_id_write_en,
    output logic              id_ex_write_en,
    output logic              ex_mem_write_en,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_mem_bubble,
    output logic              mem_wb_bubble,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [1:0]        stall_cause,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    // A latency of 1 means the MDU behaves like the ALU: no interlock at all.
    localparam logic MDU_INTERLOCK = (MDU_LATENCY > 1);
    localparam int   CNT_W         = $clog2(MDU_LATENCY + 1);
    // The RUN cycle in which the op enters EX is its first stall cycle,
    // and the final cycle (count 0) is not stalled, hence LATENCY-2.
    localparam int   MDU_LOAD      = (MDU_LATENCY > 1) ? (MDU_LATENCY - 2) : 0;

    function automatic logic [RIDX_W-1:0] widen(input logic [RW-1:0] r);
        return RIDX_W'(r);
    endfunction

    hz_state_e         state_d, state_q;
    logic [PERF_W-1:0] perf_d, perf_q;
    stall_cause_e      cause;
    fwd_sel_e          fwd_a, fwd_b;

    logic mem_wait;
    logic mdu_enter;
    logic mdu_done;
    logic mdu_stall;
    logic raw_stall;
    logic tmr_load;
    logic tmr_dec;

    assign mem_wait  = dmem_req & ~dmem_ready;
    assign mdu_enter = (state_q == RUN) & id_ex_is_mdu & MDU_INTERLOCK;
    assign mdu_stall = mdu_enter | ((state_q == MDU_BUSY) & ~mdu_done);
    // A memory wait freezes the whole MDU sequence, including its entry.
    assign tmr_load  = mdu_enter & ~mem_wait;
    assign tmr_dec   = (state_q == MDU_BUSY) & ~mem_wait;

    hazard_mdu_timer #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (MDU_LOAD)
    ) u_mdu_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .dec   (tmr_dec),
        .done  (mdu_done)
    );

`ifdef HAZARD_FORWARDING_EN
    // With forwarding only a load in EX cannot be bypassed to the ID consumer.
    logic ld_rs1, ld_rs2;
    assign ld_rs1    = raw_match(widen(id_ex_rd), id_ex_reg_write, widen(if_id_rs1), if_id_use_rs1);
    assign ld_rs2    = raw_match(widen(id_ex_rd), id_ex_reg_write, widen(if_id_rs2), if_id_use_rs2);
    assign raw_stall = id_ex_mem_read & (ld_rs1 | ld_rs2);

    // EX/MEM holds the younger value, so it wins when both stages match.
    always_comb begin
        fwd_a = FWD_RF;
        if (raw_match(widen(ex_mem_rd), ex_mem_reg_write, widen(id_ex_rs1), 1'b1)) begin
            fwd_a = FWD_MEM;
        end else if (raw_match(widen(mem_wb_rd), mem_wb_reg_write, widen(id_ex_rs1), 1'b1)) begin
            fwd_a = FWD_WB;
        end
        fwd_b = FWD_RF;
        if (raw_match(widen(ex_mem_rd), ex_mem_reg_write, widen(id_ex_rs2), 1'b1)) begin
            fwd_b = FWD_MEM;
        end else if (raw_match(widen(mem_wb_rd), mem_wb_reg_write, widen(id_ex_rs2), 1'b1)) begin
            fwd_b = FWD_WB;
        end
    end
`else
    // No bypass paths and no regfile write-through: ID waits until every
    // in-flight producer of its sources has retired.
    assign raw_stall =
        raw_match(widen(id_ex_rd),  id_ex_reg_write,  widen(if_id_rs1), if_id_use_rs1) |
        raw_match(widen(id_ex_rd),  id_ex_reg_write,  widen(if_id_rs2), if_id_use_rs2) |
        raw_match(widen(ex_mem_rd), ex_mem_reg_write, widen(if_id_rs1), if_id_use_rs1) |
        raw_match(widen(ex_mem_rd), ex_mem_reg_write, widen(if_id_rs2), if_id_use_rs2) |
        raw_match(widen(mem_wb_rd), mem_wb_reg_write, widen(if_id_rs1), if_id_use_rs1) |
        raw_match(widen(mem_wb_rd), mem_wb_reg_write, widen(if_id_rs2), if_id_use_rs2);
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{id_ex_rs1, id_ex_rs2, id_ex_mem_read};
`endif

    always_comb begin
        state_d         = state_q;
        cause           = CAUSE_NONE;
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        id_ex_write_en  = 1'b1;
        ex_mem_write_en = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_bubble    = 1'b0;
        ex_mem_bubble   = 1'b0;
        mem_wb_bubble   = 1'b0;
        fwd_a_sel       = fwd_a;
        fwd_b_sel       = fwd_b;

        if (!rst_n) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_ex_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
            if_id_flush     = 1'b1;
            id_ex_bubble    = 1'b1;
            ex_mem_bubble   = 1'b1;
            mem_wb_bubble   = 1'b1;
            fwd_a_sel       = FWD_RF;
            fwd_b_sel       = FWD_RF;
        end else if (mem_wait) begin
            // Everything up to EX/MEM holds; a pending redirect is simply
            // seen again once the wait ends since EX is frozen too.
            cause           = CAUSE_MEM;
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_ex_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
            mem_wb_bubble   = 1'b1;
        end else begin
            case (state_q)
                RUN:      if (mdu_enter) state_d = MDU_BUSY;
                MDU_BUSY: if (mdu_done)  state_d = RUN;
                default:                 state_d = RUN;
            endcase

            if (mdu_stall) begin
                cause          = CAUSE_MDU;
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                id_ex_write_en = 1'b0;
                ex_mem_bubble  = 1'b1;
            end else if (ex_redirect) begin
                // The wrong-path instruction in ID is squashed anyway, so a
                // load-use hazard against it is irrelevant.
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (raw_stall) begin
                cause          = CAUSE_RAW;
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                id_ex_bubble   = 1'b1;
            end
        end

        stall_cause    = cause;
        perf_stall_cnt = rst_n ? perf_q : '0;

        perf_d = perf_q;
        if ((cause != CAUSE_NONE) && (perf_q != '1)) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            perf_q  <= perf_d;
        end
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Pipeline hazard controller for the five-stage core. Generalises load-use stall detection, and adds EX-stage forwarding selects, a multi-cycle MDU interlock with a cycle counter, data-memory wait freeze, and branch-redirect flush.
- Drives the write-enables and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the EX operand forward muxes.

Parameters:
- REG_COUNT, 32, architectural register count; index width RW = $clog2(REG_COUNT).
- MDU_LATENCY, 8, cycles an MDU op occupies EX (>=1; 1 = no interlock).
- PERF_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- if_id_rs1, if_id_rs2  in  RW each  ID-stage source registers
- if_id_use_rs1, if_id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2
- id_ex_rs1, id_ex_rs2  in  RW each  EX-stage source registers
- id_ex_rd  in  RW  EX-stage destination
- id_ex_reg_write, id_ex_mem_read, id_ex_is_mdu  in  1 each  EX-stage controls
- ex_mem_rd, mem_wb_rd  in  RW each  MEM/WB destinations
- ex_mem_reg_write, mem_wb_reg_write  in  1 each
- ex_redirect  in  1  branch/jump resolved taken in EX
- dmem_req, dmem_ready  in  1 each  MEM-stage access handshake
- pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en  out  1 each
- if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble  out  1 each
- fwd_a_sel, fwd_b_sel  out  2 each  00 regfile, 01 MEM/WB, 10 EX/MEM
- stall_cause  out  2  00 none, 01 RAW/load-use, 10 MDU, 11 mem wait
- perf_stall_cnt  out  PERF_W  total stalled cycles

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous on rst_n, active low.
- While rst_n=0:
  - state=RUN, mdu_cnt=0, perf_stall_cnt=0.
  - All *_write_en=0; if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble=1.
  - fwd selects=00; stall_cause=00.
- RAW match(stage): stage reg_write=1 AND rd!=0 AND rd equals the compared rs AND that rs is used. x0 never matches.
- Forwarding: fwd_x_sel=10 on an EX/MEM match against id_ex_rsx, else 01 on a MEM/WB match, else 00. EX/MEM wins ties.
- Load-use: id_ex_mem_read AND an ID/EX match against if_id_rs1/rs2.
  - Response, same cycle (combinational): pc_write_en=0, if_id_write_en=0, id_ex_bubble=1.
  - Lasts exactly 1 cycle per hazard.
- Mem wait (dmem_req=1, dmem_ready=0) has highest priority.
  - PC, IF/ID, ID/EX and EX/MEM write_en=0; mem_wb_bubble=1.
  - ex_redirect is ignored and is re-evaluated once the wait ends.
  - mdu_cnt holds.
- FSM states RUN and MDU_BUSY:
  - RUN -> MDU_BUSY when id_ex_is_mdu=1, MDU_LATENCY>1 and no mem wait; load mdu_cnt=MDU_LATENCY-2.
  - In MDU_BUSY: PC, IF/ID, ID/EX write_en=0; ex_mem_bubble=1 (ex_mem_write_en=1).
  - In MDU_BUSY: mdu_cnt decrements each non-wait cycle; at mdu_cnt=0 return to RUN, and the result latches into EX/MEM on that edge.
  - With RUN entry included, the op occupies EX for MDU_LATENCY cycles.
  - The MDU op entering EX in RUN is itself stalled that cycle.
  - The MDU stall is not raised on the op's final cycle.
- Redirect (RUN, no mem wait): if_id_flush=1, id_ex_bubble=1, pc_write_en=1. Redirect overrides a simultaneous load-use stall.
- Priority: mem wait > MDU > redirect > load-use > none. stall_cause reflects the winner.
- perf_stall_cnt increments every cycle with stall_cause!=00 and saturates at all-ones.
- Reset asserted mid-MDU: FSM returns to RUN next edge and the count is discarded.

Optional Feature:
- Macro HAZARD_FORWARDING_EN.
- Defined: behaviour as above.
- Undefined:
  - fwd_a_sel and fwd_b_sel are tied to 00.
  - Any RAW match of the ID sources against ID/EX, EX/MEM or MEM/WB raises the RAW stall (cause 01).
  - That stall persists until no match remains; the regfile has no write-through.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_e (FWD_RF, FWD_WB, FWD_MEM)
  - stall_cause_e
  - hz_state_e (RUN, MDU_BUSY)
  - function raw_match(rd, reg_write, rs, use).
- One sub-module, hazard_mdu_timer: counter, load, decrement, hold, done.

Test Plan:
- Load x5 in EX, ID reads x5 -> pc_write_en=0 and id_ex_bubble=1 for exactly 1 cycle. Next cycle fwd_a_sel=01. Same test with rd=x0 -> no stall.
- EX/MEM rd=x7 and MEM/WB rd=x7, both writing, id_ex_rs2=x7 -> fwd_b_sel=10. With EX/MEM reg_write=0 -> 01.
- MDU op with MDU_LATENCY=8 -> stall_cause=10 for 7 cycles, ex_mem_bubble=1 during them, back to RUN on cycle 8. perf_stall_cnt advances by 7.
- dmem_ready low for 3 cycles mid-MDU, with ex_redirect and load-use also asserted -> cause 11 for 3 cycles, mdu_cnt frozen. MDU completes 3 cycles late; redirect is ignored throughout.
- ex_redirect together with a load-use hazard -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1, cause 00.
- rst_n=0 for 1 cycle during MDU_BUSY -> all enables 0 and bubbles 1 during reset. Counters cleared; RUN after release.
- HAZARD_FORWARDING_EN undefined, MEM/WB rd=x3, ID reads x3 -> cause 01 for 1 cycle; fwd selects stay 00.
